channel_scanner_8x4b: RTL and testbench
=======================================

// Module: channel_scanner_8x4b
// PURPOSE
//  Round-robin scanner that drives the 3-bit select of the 8:1 4-bit datapath mux and
//  captures the muxed nibble. Picks the next requesting channel, registers its select,
//  samples the mux output and hands it downstream on a valid/ready port with the channel id.
//  Sits around the mux: upstream of its select input, downstream of its data output.
// PARAMETERS
//  NCH    8  number of channels (fixed at 8; select width 3)
//  W      4  data width of mux output / captured word
//  SEL_W  3  select width, log2(NCH)
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst        in   1      synchronous reset, active-high
//  req        in   NCH    per-channel request, level
//  mux_out    in   W      data from the 8:1 mux (combinational function of sel)
//  sel        out  SEL_W  registered select to the mux
//  out_data   out  W      captured data word
//  out_chan   out  SEL_W  channel id of out_data
//  out_valid  out  1      out_data/out_chan valid
//  out_ready  in   1      downstream accepts when out_valid && out_ready
//  ack        out  NCH    one-hot, one-cycle pulse to granted requester on capture
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, ptr=0, sel=0, out_data=0, out_chan=0, out_valid=0, ack=0.
//  Eligible vector e = req (masked per CONFIGURATION). ptr = highest priority channel.
//  FSM:
//   IDLE   : if |e: g = first set bit of e searching ptr, ptr+1, ... mod 8; sel<=g; ->SETTLE.
//            else stay; sel holds.
//   SETTLE : out_data<=mux_out, out_chan<=sel, out_valid<=1, ack[sel]<=1 (one cycle); ->HOLD.
//   HOLD   : ack=0; on out_valid&&out_ready: out_valid<=0, ptr<=sel+1 (7 wraps to 0); ->IDLE.
//  Latency: req seen in IDLE at edge N -> sel valid after N -> out_valid after N+1.
//  Throughput: one word per 3 cycles with out_ready held high.
//  Data captured in SETTLE is final; req dropping after grant does not cancel capture.
//  Backpressure: in HOLD, out_data/out_chan/out_valid/sel stable until handshake.
//  No request: IDLE indefinitely, no ack, out_valid=0.
//  rst mid-operation (any state) overrides: outputs to reset values, in-flight word dropped.
//  Unused state encoding -> IDLE next cycle.
// CONFIGURATION
//  SCAN_MASK_EN defined: extra input chan_mask[NCH-1:0]; e = req & chan_mask, sampled in IDLE
//   only (mask change after grant does not affect the in-flight word).
//  SCAN_MASK_EN undefined: port absent, e = req.
// STRUCTURE
//  Shared package scan_pkg: NCH, W, SEL_W, state encodings IDLE/SETTLE/HOLD.
//  Sub-module rr_pick_8: combinational round-robin picker (e, ptr) -> (any, g).
//  Top holds FSM, ptr, output registers; mux stays external.
// TESTING (bench models mux: i_k = 4'h8+k, mux_out = i[sel])
//  1 rst=1 two cycles -> sel=0, out_valid=0, ack=0; first grant with req=8'hFF is ch0.
//  2 req=8'h08, out_ready=1 -> sel=3 after N, out_data=4'hB, out_chan=3, out_valid after N+1,
//    ack=8'h08 for exactly one cycle.
//  3 req=8'hFF, out_ready=1 -> out_chan 0,1,..,7,0 one per 3 cycles; ptr wraps 7->0.
//  4 req=8'h04, out_ready=0 for 5 cycles -> out_valid=1, out_data=4'hA stable; no new ack;
//    out_ready=1 -> handshake, out_valid=0 next cycle.
//  5 after serving ch6, req=8'h21 -> grants ch0 then ch5 (skip + wrap).
//  6 SCAN_MASK_EN: chan_mask=8'hF0, req=8'h0F -> no grant; chan_mask=8'hFF -> grant ch0.
//    rst asserted in HOLD -> out_valid=0 next cycle, next grant ch0.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared constants, FSM state encoding and select-decode helper for the
// round-robin channel scanner around the 8:1 nibble mux.
package scan_pkg;

  localparam int NCH   = 8;
  localparam int W     = 4;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  function automatic logic [NCH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NCH-1:0] v;
    v = {{(NCH-1){1'b0}}, 1'b1};
    return v << sel;
  endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Combinational round-robin picker: first set bit of the eligible vector,
// searching upward from ptr and wrapping modulo 8.
module rr_pick_8
  import scan_pkg::*;
(
  input  logic [NCH-1:0]   i_elig,
  input  logic [SEL_W-1:0] i_ptr,
  output logic             o_any,
  output logic [SEL_W-1:0] o_grant
);

  logic [2*NCH-1:0] w_dbl;
  logic [NCH-1:0]   w_rot;
  logic [SEL_W-1:0] w_off;

  // Rotate so that bit 0 of w_rot is channel ptr.
  assign w_dbl = {i_elig, i_elig};
  assign w_rot = w_dbl[i_ptr +: NCH];

  // Lowest set bit of the rotated vector; scanning downward lets the lowest win.
  always_comb begin
    w_off = {SEL_W{1'b0}};
    for (int k = NCH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = k[SEL_W-1:0];
      end else begin
        w_off = w_off;
      end
    end
  end

  assign o_any   = |i_elig;
  assign o_grant = i_ptr + w_off;

endmodule

// File: rtl/channel_scanner_8x4b.sv
// Round-robin scanner driving the external 8:1 mux select and capturing its nibble
// onto a valid/ready port. Optional SCAN_MASK_EN adds a per-channel eligibility mask.
module channel_scanner_8x4b
  import scan_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NCH-1:0]   i_req,
  input  logic [W-1:0]     i_mux_out,
`ifdef SCAN_MASK_EN
  input  logic [NCH-1:0]   i_chan_mask,
`endif
  input  logic             i_out_ready,
  output logic [SEL_W-1:0] o_sel,
  output logic [W-1:0]     o_out_data,
  output logic [SEL_W-1:0] o_out_chan,
  output logic             o_out_valid,
  output logic [NCH-1:0]   o_ack
);

  state_t           r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_sel;
  logic [W-1:0]     r_out_data;
  logic [SEL_W-1:0] r_out_chan;
  logic             r_out_valid;
  logic [NCH-1:0]   r_ack;

  logic [NCH-1:0]   w_elig;
  logic             w_any;
  logic [SEL_W-1:0] w_grant;

  // The mask only matters in IDLE, so an in-flight word is never affected by it.
`ifdef SCAN_MASK_EN
  assign w_elig = i_req & i_chan_mask;
`else
  assign w_elig = i_req;
`endif

  rr_pick_8 u_pick (
    .i_elig  (w_elig),
    .i_ptr   (r_ptr),
    .o_any   (w_any),
    .o_grant (w_grant)
  );

  // Scan FSM: grant, capture the settled mux output, then hold until accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_ptr       <= {SEL_W{1'b0}};
      r_sel       <= {SEL_W{1'b0}};
      r_out_data  <= {W{1'b0}};
      r_out_chan  <= {SEL_W{1'b0}};
      r_out_valid <= 1'b0;
      r_ack       <= {NCH{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          r_ack <= {NCH{1'b0}};
          if (w_any) begin
            r_sel   <= w_grant;
            r_state <= SETTLE;
          end else begin
            r_state <= IDLE;
          end
        end
        SETTLE: begin
          r_out_data  <= i_mux_out;
          r_out_chan  <= r_sel;
          r_out_valid <= 1'b1;
          r_ack       <= sel_onehot(r_sel);
          r_state     <= HOLD;
        end
        HOLD: begin
          r_ack <= {NCH{1'b0}};
          if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
            r_ptr       <= r_sel + 3'd1;
            r_state     <= IDLE;
          end else begin
            r_state <= HOLD;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_ack       <= {NCH{1'b0}};
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign o_sel       = r_sel;
  assign o_out_data  = r_out_data;
  assign o_out_chan  = r_out_chan;
  assign o_out_valid = r_out_valid;
  assign o_ack       = r_ack;

endmodule

// File: tb/tb_channel_scanner_8x4b.sv
// Scoreboard bench for channel_scanner_8x4b; models the 8:1 mux as i_k = 8+k.
// Define SCAN_MASK_EN to also exercise the channel mask.
module tb_channel_scanner_8x4b;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [3:0] mux_out;
  logic       out_ready;
  logic [2:0] sel;
  logic [3:0] out_data;
  logic [2:0] out_chan;
  logic       out_valid;
  logic [7:0] ack;
`ifdef SCAN_MASK_EN
  logic [7:0] chan_mask;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [6:0] sb[$];
  logic [6:0] exp_w;

  channel_scanner_8x4b dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_mux_out   (mux_out),
`ifdef SCAN_MASK_EN
    .i_chan_mask (chan_mask),
`endif
    .i_out_ready (out_ready),
    .o_sel       (sel),
    .o_out_data  (out_data),
    .o_out_chan  (out_chan),
    .o_out_valid (out_valid),
    .o_ack       (ack)
  );

  assign mux_out = 4'h8 + {1'b0, sel};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: every handshake pops the oldest expected {chan, data}.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected got chan=%0d data=%h, no word expected", out_chan, out_data);
      end else begin
        exp_w = sb.pop_front();
        if ({out_chan, out_data} !== exp_w) begin
          n_err++;
          $display("FAIL sb_word got chan=%0d data=%h, expected chan=%0d data=%h",
                   out_chan, out_data, exp_w[6:4], exp_w[3:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h00; out_ready = 1'b0;
    tick(); tick();
    n_vec++;
    if ({sel, out_valid, ack, out_data, out_chan} !== 19'h0) begin
      n_err++;
      $display("FAIL reset_state got sel=%0d valid=%b ack=%h data=%h chan=%0d, expected all 0",
               sel, out_valid, ack, out_data, out_chan);
    end
    rst = 1'b0; req = 8'hFF; out_ready = 1'b1;
    sb.push_back({3'd0, 4'h8});
    tick();
    req = 8'h00;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_first_early_valid got %b, expected 0", out_valid);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || ack !== 8'h01) begin
      n_err++; $display("FAIL reset_first_grant got valid=%b ack=%h, expected 1 01", out_valid, ack);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || ack !== 8'h00) begin
      n_err++; $display("FAIL reset_first_done got valid=%b ack=%h, expected 0 00", out_valid, ack);
    end
  endtask

  task automatic test_single();
    req = 8'h08; out_ready = 1'b1;
    sb.push_back({3'd3, 4'hB});
    tick();
    n_vec++;
    if (sel !== 3'd3 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL single_sel got sel=%0d valid=%b, expected 3 0", sel, out_valid);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 4'hB || out_chan !== 3'd3 || ack !== 8'h08) begin
      n_err++;
      $display("FAIL single_capture got valid=%b data=%h chan=%0d ack=%h, expected 1 B 3 08",
               out_valid, out_data, out_chan, ack);
    end
    req = 8'h00;
    tick();
    n_vec++;
    if (ack !== 8'h00 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL single_ack_pulse got ack=%h valid=%b, expected 00 0", ack, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      sb.push_back({3'(i % 8), 4'(8 + (i % 8))});
    end
    for (int c = 0; c < 27; c++) begin
      tick();
      if (c % 3 == 1) begin
        n_vec++;
        if (out_valid !== 1'b1 || ack !== (8'h01 << ((c / 3) % 8))) begin
          n_err++;
          $display("FAIL b2b_cadence cycle %0d got valid=%b ack=%h, expected 1 %h",
                   c, out_valid, ack, 8'h01 << ((c / 3) % 8));
        end
      end
    end
    req = 8'h00;
    n_vec++;
    if (sb.size() !== 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_drain got left=%0d valid=%b, expected 0 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_backpressure();
    req = 8'h04; out_ready = 1'b0;
    sb.push_back({3'd2, 4'hA});
    tick();
    req = 8'h00;
    tick();
    n_vec++;
    if (ack !== 8'h04) begin
      n_err++; $display("FAIL bp_ack got %h, expected 04", ack);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 4'hA || out_chan !== 3'd2 || sel !== 3'd2 || ack !== 8'h00) begin
        n_err++;
        $display("FAIL bp_hold cycle %0d got valid=%b data=%h chan=%0d sel=%0d ack=%h, expected 1 A 2 2 00",
                 c, out_valid, out_data, out_chan, sel, ack);
      end
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || sb.size() !== 0) begin
      n_err++; $display("FAIL bp_release got valid=%b left=%0d, expected 0 0", out_valid, sb.size());
    end
  endtask

  task automatic test_skip_wrap();
    req = 8'h40; out_ready = 1'b1;
    sb.push_back({3'd6, 4'hE});
    tick(); tick(); tick();
    req = 8'h21;
    sb.push_back({3'd0, 4'h8});
    sb.push_back({3'd5, 4'hD});
    tick();
    n_vec++;
    if (sel !== 3'd0) begin
      n_err++; $display("FAIL wrap_first got sel=%0d, expected 0", sel);
    end
    tick(); tick(); tick();
    n_vec++;
    if (sel !== 3'd5) begin
      n_err++; $display("FAIL wrap_second got sel=%0d, expected 5", sel);
    end
    req = 8'h00;
    tick(); tick();
    n_vec++;
    if (sb.size() !== 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL wrap_drain got left=%0d valid=%b, expected 0 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_idle();
    req = 8'h00; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || ack !== 8'h00 || sel !== 3'd5) begin
        n_err++;
        $display("FAIL idle cycle %0d got valid=%b ack=%h sel=%0d, expected 0 00 5", c, out_valid, ack, sel);
      end
    end
  endtask

  task automatic test_reset_mid();
    req = 8'hFF; out_ready = 1'b0;
    tick();
    n_vec++;
    if (sel !== 3'd6) begin
      n_err++; $display("FAIL rstmid_grant got sel=%0d, expected 6", sel);
    end
    tick();
    rst = 1'b1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0 || ack !== 8'h00 || sel !== 3'd0 || out_data !== 4'h0 || out_chan !== 3'd0) begin
      n_err++;
      $display("FAIL rstmid_clear got valid=%b ack=%h sel=%0d data=%h chan=%0d, expected 0 00 0 0 0",
               out_valid, ack, sel, out_data, out_chan);
    end
    rst = 1'b0; out_ready = 1'b1;
    sb.push_back({3'd0, 4'h8});
    tick(); tick(); tick();
    req = 8'h00;
    n_vec++;
    if (sb.size() !== 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_regrant got left=%0d valid=%b, expected 0 0", sb.size(), out_valid);
    end
  endtask

`ifdef SCAN_MASK_EN
  task automatic test_mask();
    rst = 1'b1; tick(); rst = 1'b0;
    chan_mask = 8'hF0; req = 8'h0F; out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || ack !== 8'h00) begin
        n_err++; $display("FAIL mask_block got valid=%b ack=%h, expected 0 00", out_valid, ack);
      end
    end
    chan_mask = 8'hFF;
    sb.push_back({3'd0, 4'h8});
    tick();
    n_vec++;
    if (sel !== 3'd0) begin
      n_err++; $display("FAIL mask_open got sel=%0d, expected 0", sel);
    end
    req = 8'h00;
    tick(); tick();
    n_vec++;
    if (sb.size() !== 0) begin
      n_err++; $display("FAIL mask_drain got left=%0d, expected 0", sb.size());
    end
  endtask
`endif

  initial begin
    rst = 1'b1; req = 8'h00; out_ready = 1'b0;
`ifdef SCAN_MASK_EN
    chan_mask = 8'hFF;
`endif
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_skip_wrap();
    test_idle();
    test_reset_mid();
`ifdef SCAN_MASK_EN
    test_mask();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
